// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit:
// op encoding and the WIDTH/STAGES legality rule.
package pipelined_adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Slices must tile the word exactly, one slice per stage.
    function automatic bit params_ok(int width, int stages);
        return (stages >= 1) && (stages <= width)
            && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/add_slice.sv
// SW-bit ripple of full-adder cells.
// Ports: a, b, cin in; s, cout, cmsb (carry into the MSB cell) out.
module add_slice #(
    parameter int SW = 4
) (
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] s,
    output logic          cout,
    output logic          cmsb
);

    logic [SW:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SW; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SW];
    assign cmsb = c[SW-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: one carry-chained slice per stage,
// valid/ready handshake with full-pipeline stall on backpressure.
// Ports: clk, rst_n; in_valid/in_ready, a, b, cin, sub;
//        out_valid/out_ready, s, cout (carry/borrow), ovf (signed).
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    if (!params_ok(WIDTH, STAGES)) begin : g_bad
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    logic             adv;
    logic [WIDTH-1:0] bx;

    // Subtract is a + ~b + ~cin; b is inverted once at entry so
    // later slices consume the skewed bits unchanged.
    assign bx = (sub == OP_SUB) ? ~b : b;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int RW = WIDTH - (k + 1) * SW;

        logic [SW-1:0]         sa;
        logic [SW-1:0]         sbv;
        logic [SW-1:0]         ss;
        logic                  ci;
        logic                  co;
        logic                  cm;
        logic                  vi;
        logic                  si;
        logic [(k+1)*SW-1:0]   sum_d;
        logic                  vld_q;
        logic                  sb_q;
        logic                  cy_q;
        logic                  cm_q;
        logic [(k+1)*SW-1:0]   sum_q;

        if (k == 0) begin : g_src
            assign sa    = a[SW-1:0];
            assign sbv   = bx[SW-1:0];
            assign ci    = cin ^ sub;
            assign vi    = in_valid;
            assign si    = sub;
            assign sum_d = ss;
        end else begin : g_src
            assign sa    = g_st[k-1].g_op.ra_q[SW-1:0];
            assign sbv   = g_st[k-1].g_op.rb_q[SW-1:0];
            assign ci    = g_st[k-1].cy_q;
            assign vi    = g_st[k-1].vld_q;
            assign si    = g_st[k-1].sb_q;
            assign sum_d = {ss, g_st[k-1].sum_q};
        end

        // Operand bits for the slices still ahead of this stage.
        if (k < L) begin : g_op
            logic [RW-1:0] ra_d;
            logic [RW-1:0] rb_d;
            logic [RW-1:0] ra_q;
            logic [RW-1:0] rb_q;

            if (k == 0) begin : g_d
                assign ra_d = a[WIDTH-1:SW];
                assign rb_d = bx[WIDTH-1:SW];
            end else begin : g_d
                assign ra_d = g_st[k-1].g_op.ra_q[RW+SW-1:SW];
                assign rb_d = g_st[k-1].g_op.rb_q[RW+SW-1:SW];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ra_q <= '0;
                    rb_q <= '0;
                end else if (adv) begin
                    ra_q <= ra_d;
                    rb_q <= rb_d;
                end
            end
        end

        add_slice #(.SW(SW)) u_slice (
            .a    (sa),
            .b    (sbv),
            .cin  (ci),
            .s    (ss),
            .cout (co),
            .cmsb (cm)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                sb_q  <= 1'b0;
                cy_q  <= 1'b0;
                cm_q  <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                vld_q <= vi;
                sb_q  <= si;
                cy_q  <= co;
                cm_q  <= cm;
                sum_q <= sum_d;
            end
        end
    end

    assign out_valid = g_st[L].vld_q;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign s         = g_st[L].sum_q;
    assign cout      = g_st[L].cy_q ^ g_st[L].sb_q;
    assign ovf       = g_st[L].cm_q ^ g_st[L].cy_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and random checks of pipelined_adder (STAGES 4, 1, 16)
// against a word-level reference.
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic        in_ready, out_valid, cout, ovf;
    logic [15:0] s;
    logic        in_ready1, out_valid1, cout1, ovf1;
    logic [15:0] s1;
    logic        in_ready16, out_valid16, cout16, ovf16;
    logic [15:0] s16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .s(s),
        .cout(cout), .ovf(ovf)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(in_ready1), .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid1), .out_ready(out_ready), .s(s1),
        .cout(cout1), .ovf(ovf1)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .in_ready(in_ready16), .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid16), .out_ready(out_ready), .s(s16),
        .cout(cout16), .ovf(ovf16)
    );

    // Returns {s, cout, ovf} from whole-word arithmetic.
    function automatic logic [17:0] model(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic ci,
                                          input logic sb);
        logic [15:0] yy;
        logic        cc;
        logic [16:0] full;
        logic [15:0] low;
        yy   = sb ? ~y : y;
        cc   = ci ^ sb;
        full = {1'b0, x} + {1'b0, yy} + {16'd0, cc};
        low  = {1'b0, x[14:0]} + {1'b0, yy[14:0]} + {15'd0, cc};
        return {full[15:0], full[16] ^ sb, low[15] ^ full[16]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (s !== 16'h0000) begin
            errors++;
            $display("FAIL reset_s got=%h exp=0000", s);
        end
        checks++;
        if (cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b%b exp=00", cout, ovf);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset got=%b%b exp=01",
                     out_valid, in_ready);
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sb;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    task automatic test_vectors();
        vec_t vt[7];
        int   lat;
        vt[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1};
        vt[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b1, 1'b0};
        vt[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vt[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0};
        vt[6] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            a = vt[i].a;
            b = vt[i].b;
            cin = vt[i].ci;
            sub = vt[i].sb;
            in_valid = 1'b1;
            lat = 0;
            do begin
                @(negedge clk);
                in_valid = 1'b0;
                lat++;
            end while (out_valid !== 1'b1 && lat < 20);
            checks++;
            if (lat != 4 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL vec%0d_latency got=%0d exp=4", i, lat);
            end
            checks++;
            if (s !== vt[i].s) begin
                errors++;
                $display("FAIL vec%0d_s got=%h exp=%h", i, s, vt[i].s);
            end
            checks++;
            if (cout !== vt[i].co) begin
                errors++;
                $display("FAIL vec%0d_cout got=%b exp=%b",
                         i, cout, vt[i].co);
            end
            checks++;
            if (ovf !== vt[i].ov) begin
                errors++;
                $display("FAIL vec%0d_ovf got=%b exp=%b",
                         i, ovf, vt[i].ov);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] ba[8];
        logic [15:0] bb[8];
        logic        bc[8];
        logic        bs[8];
        logic [17:0] held;
        logic [17:0] exp;
        logic        was_stall;
        int          tx;
        int          rx;
        int          stalls;
        int          extra;
        for (int i = 0; i < 8; i++) begin
            ba[i] = 16'(i * 16'h2345 + 16'h00FF);
            bb[i] = 16'hFFFF - 16'(i * 16'h0101);
            bc[i] = i[0];
            bs[i] = i[1];
        end
        tx = 0;
        rx = 0;
        stalls = 0;
        was_stall = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 8);
            #1;
            if (was_stall) begin
                checks++;
                if ({s, cout, ovf} !== held) begin
                    errors++;
                    $display("FAIL stall_hold got=%h exp=%h",
                             {s, cout, ovf}, held);
                end
            end
            if (out_valid && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready got=%b exp=0",
                             in_ready);
                end
                held = {s, cout, ovf};
                was_stall = 1'b1;
                stalls++;
            end else begin
                was_stall = 1'b0;
            end
            if (out_valid && out_ready) begin
                exp = model(ba[rx], bb[rx], bc[rx], bs[rx]);
                checks++;
                if ({s, cout, ovf} !== exp) begin
                    errors++;
                    $display("FAIL b2b_beat%0d got=%h exp=%h",
                             rx, {s, cout, ovf}, exp);
                end
                rx++;
            end
            if (tx < 8) begin
                in_valid = 1'b1;
                a = ba[tx];
                b = bb[tx];
                cin = bc[tx];
                sub = bs[tx];
                if (in_ready) tx++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (rx != 8) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=8", rx);
        end
        checks++;
        if (stalls != 3) begin
            errors++;
            $display("FAIL b2b_stall_cycles got=%0d exp=3", stalls);
        end
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL b2b_extra_results got=%0d exp=0", extra);
        end
    endtask

    task automatic test_reset_inflight();
        int stale;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a = 16'h1111;
            b = 16'h2222;
            cin = 1'b0;
            sub = 1'b0;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || s !== 16'h3333) begin
            errors++;
            $display("FAIL inflight_pre got=%b/%h exp=1/3333",
                     out_valid, s);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (s !== 16'h0000 || cout !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_data got=%h%b%b exp=000000",
                     s, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        checks++;
        if (stale != 0) begin
            errors++;
            $display("FAIL stale_after_reset got=%0d exp=0", stale);
        end
        a = 16'h0101;
        b = 16'h0202;
        in_valid = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
        end while (out_valid !== 1'b1 && lat < 20);
        checks++;
        if (lat != 4 || s !== 16'h0303) begin
            errors++;
            $display("FAIL post_rst_beat got=%0d/%h exp=4/0303", lat, s);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        localparam int N = 1000;
        logic [15:0] ra[N];
        logic [15:0] rb[N];
        logic        rc[N];
        logic        rs[N];
        logic [18:0] got;
        logic [18:0] exp;
        int          idx;
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < N + 20; t++) begin
            @(negedge clk);
            idx = t - 4;
            got = {out_valid, s, cout, ovf};
            exp = (idx >= 0 && idx < N)
                ? {1'b1, model(ra[idx], rb[idx], rc[idx], rs[idx])}
                : {1'b0, got[17:0]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rand_s4 t=%0d got=%h exp=%h", t, got, exp);
            end
            idx = t - 1;
            got = {out_valid1, s1, cout1, ovf1};
            exp = (idx >= 0 && idx < N)
                ? {1'b1, model(ra[idx], rb[idx], rc[idx], rs[idx])}
                : {1'b0, got[17:0]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rand_s1 t=%0d got=%h exp=%h", t, got, exp);
            end
            idx = t - 16;
            got = {out_valid16, s16, cout16, ovf16};
            exp = (idx >= 0 && idx < N)
                ? {1'b1, model(ra[idx], rb[idx], rc[idx], rs[idx])}
                : {1'b0, got[17:0]};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rand_s16 t=%0d got=%h exp=%h",
                         t, got, exp);
            end
            if (t < N) begin
                ra[t] = 16'($urandom);
                rb[t] = 16'($urandom);
                rc[t] = 1'($urandom);
                rs[t] = 1'($urandom);
                a = ra[t];
                b = rb[t];
                cin = rc[t];
                sub = rs[t];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined add/subtract unit that generalises the team's single-bit full adder to a WIDTH-bit operand split into STAGES carry-chained slices, one slice per pipeline stage. Adds optional subtract mode, signed-overflow detection and a valid/ready handshake with backpressure, so it can sit directly in streaming datapaths (accumulators, address generators) where a long combinational carry chain would miss timing.

## Interface
- WIDTH, 16: operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4: pipeline depth and slice count; 1 ≤ STAGES ≤ WIDTH. Slice width SW = WIDTH/STAGES.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (subtract).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- s  output  WIDTH  sum/difference.
- cout  output  1  carry-out (add) or borrow-out (subtract).
- ovf  output  1  two's-complement signed overflow.

## Operation
- Arithmetic: add: {cout,s} = a + b + cin. Subtract: s = a − b − cin, computed as a + ~b + ~cin; cout = NOT(raw carry) = borrow-out.
- ovf = carry into bit WIDTH−1 XOR raw carry out of bit WIDTH−1 (same rule for both modes).
- Stage k (0..STAGES−1) computes bits [k·SW +: SW] using the carry registered by stage k−1 (stage 0 uses cin XOR sub); later-slice operand bits and sub ride along in pipeline registers; completed sum slices accumulate toward the output.
- Stall: advance = !out_valid || out_ready. When advance=0 every stage register, including valid bits, holds. in_ready = advance. No bubble collapsing.
- Beat accepted when in_valid && in_ready; result delivered when out_valid && out_ready.
- Results emerge in strict input order; each accepted beat yields exactly one result.
- Outputs s, cout, ovf stable while out_valid && !out_ready.

## Timing
- Reset (async assert, sync release): all valid bits 0, all data registers 0; out_valid=0, s=0, cout=0, ovf=0; in_ready=1.
- Latency: STAGES cycles from acceptance edge to out_valid high, with no stall.
- Throughput: one beat per cycle when out_ready held high.
- Stall of N cycles adds exactly N cycles to latency of every beat in flight.
- Simultaneous in_valid and output acceptance on a full pipeline: both handshakes complete in the same cycle.
- in_valid=0 while advancing inserts a bubble; bubbles are propagated, never emitted.
- Reset mid-operation: all in-flight beats discarded, no partial result ever visible; first post-reset beat obeys normal latency.
- STAGES=1: fully combinational sum registered once; latency 1.

## Structure
- Shared package: op encoding constants OP_ADD=1'b0, OP_SUB=1'b1; parameter legality check (WIDTH % STAGES == 0) as elaboration-time assertion.
- One sub-module: add_slice (SW-bit ripple of full-adder cells, inputs a, b, cin, outputs s, cout, plus carry into its MSB for overflow). Instantiated STAGES times via generate.
- Top handles pipeline registers, operand skew, handshake and stall.

## Test plan
- WIDTH=16, STAGES=4: a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 cycles s=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, add -> s=0x8000, cout=0, ovf=1; a=0x8000, b=0x0001, sub -> s=0x7FFF, cout=0, ovf=1.
- a=0x0005, b=0x0007, sub, cin=1 -> s=0xFFFD, cout=1 (borrow), ovf=0.
- 8 back-to-back beats, out_ready low for 3 cycles mid-stream -> in_ready low during stall, all 8 results in order, none duplicated or lost, outputs stable while stalled.
- Assert rst_n with 3 beats in flight -> out_valid=0, s=0 immediately (asynchronous); no stale result after release; next beat latency 4.
- STAGES=1 and STAGES=16 builds: 1000 random beats vs reference model -> bit-exact s, cout, ovf; latency 1 and 16 respectively.
